// File: rtl/controller_genius_if.sv
// Bundle between the Genius control FSM and the game datapath.
//   Status flags (datapath -> controller): end_FPGA, end_User, end_time, win, match
//   Controls     (controller -> datapath): R1, R2, E1..E4, SEL, state_o
// The master modport belongs to the controller, the slave modport to the datapath.
interface controller_genius_if;
    logic       end_FPGA;
    logic       end_User;
    logic       end_time;
    logic       win;
    logic       match;
    logic       R1;
    logic       R2;
    logic       E1;
    logic       E2;
    logic       E3;
    logic       E4;
    logic       SEL;
    logic [2:0] state_o;

    modport master (
        input  end_FPGA, end_User, end_time, win, match,
        output R1, R2, E1, E2, E3, E4, SEL, state_o
    );

    modport slave (
        output end_FPGA, end_User, end_time, win, match,
        input  R1, R2, E1, E2, E3, E4, SEL, state_o
    );
endinterface

// File: rtl/controller_genius.sv
// Moore control FSM for the Genius (Simon) memory game.
//   CLOCK_50 : system clock, rising edge
//   reset    : synchronous, active-high
//   KEY      : active-low push buttons, KEY[p_enter_idx] is ENTER (asynchronous)
//   bus      : master side of controller_genius_if (datapath status in, resets/enables out)
module controller_genius #(
    parameter int unsigned p_key       = 4,
    parameter int unsigned p_enter_idx = 0
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic [p_key-1:0]   KEY,
    controller_genius_if.master bus
);

    typedef enum logic [2:0] {
        StInit      = 3'd0,
        StSetup     = 3'd1,
        StPrep      = 3'd2,
        StPlayFpga  = 3'd3,
        StPlayUser  = 3'd4,
        StCheck     = 3'd5,
        StNextRound = 3'd6,
        StResult    = 3'd7
    } state_t;

    state_t state_q, state_d;
    logic   phase_q, phase_d;

    logic key_meta, key_sync, key_prev;
    logic enter_pulse;

    // Only the ENTER bit is consumed; the rest of the bus is reserved for the datapath.
    logic unused_key_bits;
    assign unused_key_bits = ^KEY;

    // Two-flop synchroniser plus one delay flop for falling-edge detection.
    // All three reset to 1 (released) so no spurious press follows reset.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            key_meta <= 1'b1;
            key_sync <= 1'b1;
            key_prev <= 1'b1;
        end else begin
            key_meta <= KEY[p_enter_idx];
            key_sync <= key_meta;
            key_prev <= key_sync;
        end
    end

    assign enter_pulse = key_prev & ~key_sync;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= StInit;
            phase_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = 1'b0;
        case (state_q)
            StInit:     state_d = StSetup;
            StSetup:    if (enter_pulse) state_d = StPrep;
            StPrep:     state_d = StPlayFpga;
            StPlayFpga: if (bus.end_FPGA) state_d = StPlayUser;
            StPlayUser: begin
                // A timeout loses the round even if the last button landed together with it.
                if (bus.end_time) begin
                    state_d = StResult;
                end else if (bus.end_User) begin
                    state_d = StCheck;
                end
            end
            StCheck:    state_d = bus.match ? StNextRound : StResult;
            StNextRound: begin
                // Phase 0 pulses E4; phase 1 waits for the round counter's win flag to settle.
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    state_d = bus.win ? StResult : StPrep;
                end
            end
            StResult:   if (enter_pulse) state_d = StInit;
            default:    state_d = StInit;
        endcase
    end

    always_comb begin
        bus.R1      = 1'b0;
        bus.R2      = 1'b0;
        bus.E1      = 1'b0;
        bus.E2      = 1'b0;
        bus.E3      = 1'b0;
        bus.E4      = 1'b0;
        bus.SEL     = 1'b1;
        bus.state_o = state_q;
        case (state_q)
            StInit: begin
                bus.R1 = 1'b1;
                bus.R2 = 1'b1;
            end
            StSetup:     bus.E1 = 1'b1;
            StPrep:      bus.R2 = 1'b1;
            StPlayFpga:  bus.E3 = 1'b1;
            StPlayUser:  bus.E2 = 1'b1;
            StCheck:     ;
            StNextRound: bus.E4 = ~phase_q;
            StResult:    bus.SEL = 1'b0;
            default:     ;
        endcase
    end

endmodule
